// File: rtl/sccb_init_sequencer.sv
// ---------------------------------------------------------------------------
// sccb_init_sequencer
//
// Walks a combinational register-configuration ROM of {addr, value, rw}
// entries and issues each entry to an SCCB/I2C master over a req/done
// handshake. Two reserved {addr,value} codes are recognised: END_MARK stops
// the walk successfully and DELAY_MARK idles for DELAY_CYCLES clocks. A NACK
// aborts the sequence and records the failing index.
//
// Optional feature macro: READBACK_VERIFY_EN
//   When defined, every successful write is followed, after one idle cycle,
//   by a read of the same address. A NACK or a value that differs from the
//   written one aborts at that index.
//
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   start_i           start from index 0 (honoured only when not busy)
//   index_o/entry_i   ROM address out, {addr,value,rw} entry back
//   req_o, rw_o,      transfer request to the master with its address,
//   addr_o, wdata_o   write value and direction (1 = write)
//   done_i, nack_i,   master completion pulse, NACK flag and read data
//   rdata_i
//   rd_valid_o,       one-cycle pulse with the value of a table read
//   rd_data_o
//   busy_o, done_o,   sequence status; done_o/err_o are levels that hold
//   err_o,            until the next start or reset
//   err_index_o       index of the entry that failed
// ---------------------------------------------------------------------------
module sccb_init_sequencer #(
    parameter int                        ADDR_W       = 8,
    parameter int                        DATA_W       = 8,
    parameter int                        IDX_W        = 6,
    parameter int                        DELAY_CYCLES = 1000000,
    parameter logic [ADDR_W+DATA_W-1:0]  END_MARK     = '1,
    parameter logic [ADDR_W+DATA_W-1:0]  DELAY_MARK   = 16'hF0F0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    output logic [IDX_W-1:0]         index_o,
    input  logic [ADDR_W+DATA_W:0]   entry_i,
    output logic                     req_o,
    output logic                     rw_o,
    output logic [ADDR_W-1:0]        addr_o,
    output logic [DATA_W-1:0]        wdata_o,
    input  logic                     done_i,
    input  logic                     nack_i,
    input  logic [DATA_W-1:0]        rdata_i,
    output logic                     rd_valid_o,
    output logic [DATA_W-1:0]        rd_data_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [IDX_W-1:0]         err_index_o
);

    // A zero delay still spends one cycle in PAUSE.
    localparam int                DLY      = (DELAY_CYCLES < 1) ? 1 : DELAY_CYCLES;
    localparam int                CNT_W    = (DLY > 1) ? $clog2(DLY) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DLY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_XFER,
        S_PAUSE,
        S_DONE,
        S_ERR
`ifdef READBACK_VERIFY_EN
        , S_VERIFY
`endif
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          index_d, err_index_d;
    logic                      req_d, rw_d, rd_valid_d, busy_d, done_d, err_d;
    logic [ADDR_W-1:0]         addr_d;
    logic [DATA_W-1:0]         wdata_d, rd_data_d;
    logic                      advance, finish, fail;
`ifdef READBACK_VERIFY_EN
    // Low during the idle cycle that separates a write from its readback.
    logic                      vfy_issued_q, vfy_issued_d;
`endif

    logic [ADDR_W+DATA_W-1:0]  entry_key;
    assign entry_key = entry_i[ADDR_W+DATA_W:1];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default would infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        index_d     = index_o;
        req_d       = req_o;
        rw_d        = rw_o;
        addr_d      = addr_o;
        wdata_d     = wdata_o;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_o;
        busy_d      = busy_o;
        done_d      = done_o;
        err_d       = err_o;
        err_index_d = err_index_o;
        advance     = 1'b0;
        finish      = 1'b0;
        fail        = 1'b0;
`ifdef READBACK_VERIFY_EN
        vfy_issued_d = vfy_issued_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    index_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // index_o has been stable for a full cycle, so entry_i is settled.
                if (entry_key == END_MARK) begin
                    finish = 1'b1;
                end else if (entry_key == DELAY_MARK) begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_PAUSE;
                end else begin
                    addr_d  = entry_i[ADDR_W+DATA_W -: ADDR_W];
                    wdata_d = entry_i[DATA_W:1];
                    rw_d    = entry_i[0];
                    req_d   = 1'b1;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (done_i) begin
                    req_d = 1'b0;
                    if (nack_i) begin
                        fail = 1'b1;
                    end else if (!rw_o) begin
                        rd_data_d  = rdata_i;
                        rd_valid_d = 1'b1;
                        advance    = 1'b1;
                    end else begin
`ifdef READBACK_VERIFY_EN
                        vfy_issued_d = 1'b0;
                        state_d      = S_VERIFY;
`else
                        advance = 1'b1;
`endif
                    end
                end
            end
            S_PAUSE: begin
                if (cnt_q == '0) advance = 1'b1;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
`ifdef READBACK_VERIFY_EN
            S_VERIFY: begin
                if (!vfy_issued_q) begin
                    req_d        = 1'b1;
                    rw_d         = 1'b0;
                    vfy_issued_d = 1'b1;
                end else if (done_i) begin
                    req_d = 1'b0;
                    if (nack_i || (rdata_i != wdata_o)) fail    = 1'b1;
                    else                                advance = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // The last table slot ends the walk even without an end marker.
        if (advance) begin
            if (index_o == '1) begin
                finish = 1'b1;
            end else begin
                index_d = index_o + IDX_W'(1);
                state_d = S_FETCH;
            end
        end

        if (finish) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        if (fail) begin
            state_d     = S_ERR;
            busy_d      = 1'b0;
            err_d       = 1'b1;
            err_index_d = index_o;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register updates from the
        // values present before the edge.
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            index_o     <= '0;
            req_o       <= 1'b0;
            rw_o        <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_index_o <= '0;
`ifdef READBACK_VERIFY_EN
            vfy_issued_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            index_o     <= index_d;
            req_o       <= req_d;
            rw_o        <= rw_d;
            addr_o      <= addr_d;
            wdata_o     <= wdata_d;
            rd_valid_o  <= rd_valid_d;
            rd_data_o   <= rd_data_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            err_o       <= err_d;
            err_index_o <= err_index_d;
`ifdef READBACK_VERIFY_EN
            vfy_issued_q <= vfy_issued_d;
`endif
        end
    end

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sccb_init_sequencer
//
// Drives sccb_init_sequencer (IDX_W=3, DELAY_CYCLES=8) from a table held in
// the bench, answers its requests with a small SCCB slave (random latency,
// planned NACKs, stray done pulses outside transfers) and compares the
// observed transfers, read results, spacing and final status with a
// table-walking reference model. READBACK_VERIFY_EN, when defined, is
// honoured by both the slave and the model.
// ---------------------------------------------------------------------------
module tb_sccb_init_sequencer;

    localparam int           IDX_W   = 3;
    localparam int           DEPTH   = 1 << IDX_W;
    localparam int           DLY     = 8;
    localparam int           BUDGET  = 5000;
    localparam logic [15:0]  END_KEY = 16'hFFFF;
    localparam logic [15:0]  DLY_KEY = 16'hF0F0;

    typedef struct {
        logic [7:0] addr;
        logic       rw;
        logic [7:0] wdata;
        int         gap;
    } txn_t;

    logic             clk_i = 1'b0;
    logic             rst_i, start_i;
    logic [IDX_W-1:0] index_o, err_index_o;
    logic [16:0]      entry_i;
    logic             req_o, rw_o, done_i, nack_i, rd_valid_o;
    logic [7:0]       addr_o, wdata_o, rdata_i, rd_data_o;
    logic             busy_o, done_o, err_o;

    logic [16:0]      rom [DEPTH];
    logic [7:0]       smem [256];
    logic [7:0]       mmem [256];
    int               nack_idx = -1;
    int               corrupt_idx = -1;

    int               n_vec = 0;
    int               n_err = 0;

    txn_t             exp_q[$], obs_q[$];
    logic [7:0]       exp_rd[$], obs_rd[$];
    bit               exp_done, exp_err;
    int               exp_eidx, exp_final;

    int               cyc = 0, start_cyc = 0, fall_cyc = 0, unstable = 0;
    logic             req_prev = 1'b0, p_rw = 1'b0;
    logic [7:0]       p_addr = '0, p_wdata = '0;
    txn_t             mon_t;
    bit               pending;
    int               wait_cnt;

    always #5 clk_i = ~clk_i;

    assign entry_i = rom[index_o];

    sccb_init_sequencer #(
        .ADDR_W(8), .DATA_W(8), .IDX_W(IDX_W), .DELAY_CYCLES(DLY)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .index_o(index_o), .entry_i(entry_i),
        .req_o(req_o), .rw_o(rw_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .done_i(done_i), .nack_i(nack_i), .rdata_i(rdata_i),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_index_o(err_index_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Slave: answers each request after 0..3 extra cycles; issues stray done
    // pulses (sometimes with nack) while no request is outstanding.
    initial begin
        done_i = 1'b0; nack_i = 1'b0; rdata_i = '0; pending = 0; wait_cnt = 0;
        forever begin
            @(negedge clk_i);
            done_i = 1'b0;
            nack_i = 1'b0;
            if (rst_i) begin
                pending = 0;
            end else if (pending) begin
                if (wait_cnt == 0) begin
                    pending = 0;
                    done_i  = 1'b1;
                    if (int'(index_o) == nack_idx && rw_o == rom[index_o][0]) nack_i = 1'b1;
                    else if (rw_o) smem[addr_o] = wdata_o;
                    rdata_i = smem[addr_o];
                    if (!rw_o && int'(index_o) == corrupt_idx && rom[index_o][0])
                        rdata_i = rdata_i ^ 8'h01;
                end else begin
                    wait_cnt--;
                end
            end else if (req_o) begin
                pending  = 1;
                wait_cnt = $urandom_range(0, 3);
            end else if ($urandom_range(0, 7) == 0) begin
                done_i  = 1'b1;
                nack_i  = 1'($urandom_range(0, 1));
                rdata_i = 8'($urandom);
            end
        end
    end

    // Monitor: records each request with the number of cycles since start
    // (first request) or since req_o last fell, plus every read pulse.
    initial forever begin
        @(negedge clk_i);
        if (req_o && !req_prev) begin
            mon_t.addr  = addr_o;
            mon_t.rw    = rw_o;
            mon_t.wdata = wdata_o;
            mon_t.gap   = (obs_q.size() == 0) ? cyc - start_cyc : cyc - fall_cyc;
            obs_q.push_back(mon_t);
        end
        if (!req_o && req_prev) fall_cyc = cyc;
        if (req_o && req_prev && (addr_o != p_addr || rw_o != p_rw || wdata_o != p_wdata))
            unstable++;
        if (rd_valid_o) obs_rd.push_back(rd_data_o);
        req_prev = req_o;
        p_addr   = addr_o;
        p_rw     = rw_o;
        p_wdata  = wdata_o;
    end

    // Reference: walk the table entry by entry. Each delay marker costs one
    // fetch plus DLY pause cycles; a transfer is requested two cycles after
    // start, or one cycle after the previous request dropped.
    task automatic model_run();
        int         k;
        bit         first;
        logic [16:0] e;
        txn_t       t;
        exp_q.delete();
        exp_rd.delete();
        exp_err   = 0;
        exp_eidx  = 0;
        exp_final = 0;
        k         = 0;
        first     = 1;
        mmem      = smem;
        for (int i = 0; i < DEPTH; i++) begin
            exp_final = i;
            e = rom[i];
            if (e[16:1] == END_KEY) break;
            if (e[16:1] == DLY_KEY) begin
                k++;
                continue;
            end
            t.addr  = e[16:9];
            t.rw    = e[0];
            t.wdata = e[8:1];
            t.gap   = (first ? 2 : 1) + (DLY + 1) * k;
            exp_q.push_back(t);
            first = 0;
            k     = 0;
            if (i == nack_idx) begin
                exp_err  = 1;
                exp_eidx = i;
                break;
            end
            if (!e[0]) begin
                exp_rd.push_back(mmem[t.addr]);
            end else begin
                mmem[t.addr] = t.wdata;
`ifdef READBACK_VERIFY_EN
                t.rw  = 1'b0;
                t.gap = 1;
                exp_q.push_back(t);
                if (i == corrupt_idx) begin
                    exp_err  = 1;
                    exp_eidx = i;
                    break;
                end
`endif
            end
        end
        exp_done = !exp_err;
    endtask

    task automatic run_table(input string name);
        int waited;
        model_run();
        @(negedge clk_i);
        obs_q.delete();
        obs_rd.delete();
        unstable  = 0;
        start_cyc = cyc;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        waited  = 0;
        while (!(done_o || err_o) && waited < BUDGET) begin
            @(negedge clk_i);
            waited++;
            // Starts while busy must be ignored.
            start_i = (busy_o && $urandom_range(0, 15) == 0);
        end
        start_i = 1'b0;
        check({name, " timeout"}, (waited < BUDGET), 1);
        check({name, " done_o"}, done_o, exp_done);
        check({name, " err_o"}, err_o, exp_err);
        check({name, " busy_o"}, busy_o, 0);
        check({name, " req_o"}, req_o, 0);
        check({name, " index_o"}, index_o, exp_final);
        if (exp_err) check({name, " err_index_o"}, err_index_o, exp_eidx);
        check({name, " n_xfer"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s xfer%0d addr", name, i), obs_q[i].addr, exp_q[i].addr);
            check($sformatf("%s xfer%0d rw", name, i), obs_q[i].rw, exp_q[i].rw);
            check($sformatf("%s xfer%0d wdata", name, i), obs_q[i].wdata, exp_q[i].wdata);
            check($sformatf("%s xfer%0d spacing", name, i), obs_q[i].gap, exp_q[i].gap);
        end
        check({name, " req_stable"}, unstable, 0);
        check({name, " n_rd"}, obs_rd.size(), exp_rd.size());
        for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
            check($sformatf("%s rd%0d", name, i), obs_rd[i], exp_rd[i]);
    endtask

    function automatic logic [16:0] rand_entry();
        logic [15:0] key;
        key = 16'($urandom);
        if (key == END_KEY || key == DLY_KEY) key = key ^ 16'h0100;
        return {key, 1'($urandom_range(0, 1))};
    endfunction

    task automatic randomize_mem();
        for (int a = 0; a < 256; a++) smem[a] = 8'($urandom);
    endtask

    task automatic fill_rom(input logic [16:0] fill);
        for (int i = 0; i < DEPTH; i++) rom[i] = fill;
    endtask

    initial begin
        int waited;
        rst_i   = 1'b1;
        start_i = 1'b0;
        fill_rom({END_KEY, 1'b0});
        randomize_mem();
        repeat (3) @(negedge clk_i);
        check("rst req_o", req_o, 0);
        check("rst busy_o", busy_o, 0);
        check("rst done_o", done_o, 0);
        check("rst err_o", err_o, 0);
        check("rst index_o", index_o, 0);
        check("rst addr_o", addr_o, 0);
        check("rst wdata_o", wdata_o, 0);
        check("rst rw_o", rw_o, 0);
        check("rst rd_valid_o", rd_valid_o, 0);
        check("rst rd_data_o", rd_data_o, 0);
        check("rst err_index_o", err_index_o, 0);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Two writes around a delay marker, then end.
        fill_rom({END_KEY, 1'b0});
        rom[0] = {16'h1280, 1'b1};
        rom[1] = {DLY_KEY, 1'b1};
        rom[2] = {16'h1204, 1'b1};
        rom[3] = {END_KEY, 1'b1};
        run_table("delay");

        // Single read entry.
        fill_rom({END_KEY, 1'b0});
        rom[0] = {16'h0A76, 1'b0};
        smem[8'h0A] = 8'h76;
        run_table("read");

        // NACK on entry 2, then rerun cleanly.
        fill_rom({END_KEY, 1'b0});
        for (int i = 0; i < 4; i++) rom[i] = {8'(8'h20 + i), 8'(8'h50 + i), 1'b1};
        nack_idx = 2;
        run_table("nack");
        nack_idx = -1;
        run_table("rerun");

        // Full table with no end marker: stops at the last index.
        for (int i = 0; i < DEPTH; i++) rom[i] = rand_entry();
        run_table("no_end");

        // Full table ending in a delay marker.
        for (int i = 0; i < DEPTH; i++) rom[i] = rand_entry();
        rom[DEPTH-1] = {DLY_KEY, 1'b0};
        run_table("tail_delay");

`ifdef READBACK_VERIFY_EN
        fill_rom({END_KEY, 1'b0});
        rom[0] = {16'h1204, 1'b1};
        corrupt_idx = 0;
        run_table("verify_bad");
        corrupt_idx = -1;
        run_table("verify_ok");
`endif

        // Reset while a request is outstanding.
        fill_rom({END_KEY, 1'b0});
        for (int i = 0; i < 4; i++) rom[i] = {8'(8'h30 + i), 8'(8'h11 * i), 1'b1};
        @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        waited  = 0;
        while (!req_o && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        check("mid_rst req seen", req_o, 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mid_rst req_o", req_o, 0);
        check("mid_rst busy_o", busy_o, 0);
        check("mid_rst index_o", index_o, 0);
        check("mid_rst done_o", done_o, 0);
        rst_i = 1'b0;
        repeat (6) @(negedge clk_i);

        // Random tables: markers, reads, writes, occasional NACK / bad readback.
        for (int n = 0; n < 25; n++) begin
            randomize_mem();
            for (int i = 0; i < DEPTH; i++) begin
                case ($urandom_range(0, 9))
                    0:       rom[i] = {DLY_KEY, 1'($urandom_range(0, 1))};
                    1:       rom[i] = (i > 0) ? {END_KEY, 1'($urandom_range(0, 1))} : rand_entry();
                    default: rom[i] = rand_entry();
                endcase
            end
            nack_idx    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : -1;
            corrupt_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, DEPTH - 1) : -1;
            run_table($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
